shake_arbiter: RTL and testbench

SHAKE_ARBITER -- requirements
Module: shake_arbiter

---
 rtl/shake_arbiter_pkg.sv | 18 +
 rtl/shake_arbiter_if.sv | 44 ++++
 rtl/shake_arbiter_rr_pick.sv | 42 ++++
 rtl/shake_arbiter.sv | 129 ++++++++++++
 tb/tb_shake_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shake_arbiter_pkg.sv
// Shared types and defaults for the SHAKE256 core arbiter.
package shake_arb_pkg;

    localparam int SHAKE_DW_DEFAULT      = 32;
    localparam int SHAKE_TIMEOUT_DEFAULT = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shake_arbiter_if.sv
// Requester-side and core-side handshake bundle of the SHAKE arbiter.
interface shake_arbiter_if
    import shake_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DW      = SHAKE_DW_DEFAULT
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    r_din_valid;
    logic [NUM_REQ*DW-1:0] r_din;
    logic [NUM_REQ-1:0]    r_din_ready;
    logic [NUM_REQ-1:0]    r_dout_valid;
    logic [NUM_REQ*DW-1:0] r_dout;
    logic [NUM_REQ-1:0]    r_dout_ready;
    logic [NUM_REQ-1:0]    r_force_done;
    logic                  shake_din_valid;
    logic [DW-1:0]         shake_din;
    logic                  shake_din_ready;
    logic                  shake_dout_valid;
    logic                  shake_dout_ready;
    logic [DW-1:0]         shake_dout;
    logic                  shake_force_done;
    logic                  err_timeout;

    // Arbiter side.
    modport slave (
        input  req, r_din_valid, r_din, r_dout_ready, r_force_done,
        input  shake_din_ready, shake_dout_valid, shake_dout,
        output gnt, r_din_ready, r_dout_valid, r_dout,
        output shake_din_valid, shake_din, shake_dout_ready, shake_force_done,
        output err_timeout
    );

    // Requesters plus core, as seen from outside the arbiter.
    modport master (
        output req, r_din_valid, r_din, r_dout_ready, r_force_done,
        output shake_din_ready, shake_dout_valid, shake_dout,
        input  gnt, r_din_ready, r_dout_valid, r_dout,
        input  shake_din_valid, shake_din, shake_dout_ready, shake_force_done,
        input  err_timeout
    );

endinterface

// File: rtl/shake_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_pick
    import shake_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PW      = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PW-1:0]      idx
);

    logic [PW:0] cand [NUM_REQ];
    logic        found;

    // cand[gi] is the requester index sitting gi places after rr_ptr.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [PW:0] sum;
        assign sum       = {1'b0, rr_ptr} + (PW+1)'(gi);
        assign cand[gi]  = (sum >= (PW+1)'(NUM_REQ)) ? sum - (PW+1)'(NUM_REQ) : sum;
    end

    // Scan offsets from far to near so the nearest requester wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req[j] && (cand[i] == (PW+1)'(j))) begin
                    idx   = PW'(j);
                    found = 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_winner
        assign winner[gi] = found && (idx == PW'(gi));
    end

endmodule

// File: rtl/shake_arbiter.sv
// Shares one SHAKE256 core among NUM_REQ requesters, one session at a time.
// Optional session watchdog enabled by defining SHAKE_ARB_WATCHDOG_EN.
module shake_arbiter
    import shake_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DW      = SHAKE_DW_DEFAULT,
    parameter int TIMEOUT = SHAKE_TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    shake_arbiter_if.slave  bus
);

    localparam int PW = ptr_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2) begin : g_param_check
        $error("shake_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 2");
    end

    arb_state_t         state_reg, state_next;
    logic [PW-1:0]      owner_reg, owner_next;
    logic [PW-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [PW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] gnt_vec;
    logic               in_grant;
    logic               owner_done;
    logic               wd_expire;
    logic               session_end;
    logic [DW-1:0]      shake_din_mux;

    rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr_reg),
        .winner (pick_onehot),
        .idx    (pick_idx)
    );

    assign in_grant = (state_reg == GRANT);

    // Everything owner-facing is gated by gnt_vec, so IDLE/RELEASE drive zeros.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_route
        assign gnt_vec[gi]               = in_grant && (owner_reg == PW'(gi));
        assign bus.r_din_ready[gi]       = gnt_vec[gi] & bus.shake_din_ready;
        assign bus.r_dout_valid[gi]      = gnt_vec[gi] & bus.shake_dout_valid;
        assign bus.r_dout[gi*DW +: DW]   = gnt_vec[gi] ? bus.shake_dout : '0;
    end

    always_comb begin
        shake_din_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_vec[i]) begin
                shake_din_mux = bus.r_din[i*DW +: DW];
            end
        end
    end

    assign bus.gnt              = gnt_vec;
    assign bus.shake_din        = shake_din_mux;
    assign bus.shake_din_valid  = |(gnt_vec & bus.r_din_valid);
    assign bus.shake_dout_ready = |(gnt_vec & bus.r_dout_ready);
    assign owner_done           = |(gnt_vec & bus.r_force_done);
    assign session_end          = owner_done | wd_expire;
    assign bus.shake_force_done = session_end;

`ifdef SHAKE_ARB_WATCHDOG_EN
    localparam int WW = ptr_width(TIMEOUT);

    logic [WW-1:0] wd_count_reg;
    logic          core_hs;

    assign core_hs = (bus.shake_din_valid & bus.shake_din_ready) |
                     (bus.shake_dout_valid & bus.shake_dout_ready);

    // Held at zero outside GRANT, so every session starts counting from 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_count_reg <= '0;
        end else if (!in_grant || core_hs) begin
            wd_count_reg <= '0;
        end else begin
            wd_count_reg <= wd_count_reg + WW'(1);
        end
    end

    assign wd_expire       = in_grant && (wd_count_reg == WW'(TIMEOUT - 1));
    assign bus.err_timeout = wd_expire;
`else
    assign wd_expire       = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            owner_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (|pick_onehot) begin
                    owner_next = pick_idx;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                // Dropping req alone never releases; only force_done or the watchdog do.
                if (session_end) begin
                    state_next  = RELEASE;
                    rr_ptr_next = (owner_reg == PW'(NUM_REQ - 1)) ? '0 : owner_reg + PW'(1);
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shake_arbiter.sv
// Scoreboard bench for shake_arbiter with a small behavioural core model on the core side.
module tb_shake_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;

    logic clk;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    logic [DW-1:0] exp_din_q[$];
    logic [DW-1:0] exp_dout_q[$];

    shake_arbiter_if #(.NUM_REQ(NR), .DW(DW)) bus ();

    shake_arbiter #(.NUM_REQ(NR), .DW(DW), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL sim_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [DW-1:0] mix(input logic [DW-1:0] acc, input int k);
        return {acc[26:0], acc[31:27]} ^ (32'(k) * 32'h9E37_79B9);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req              = '0;
        bus.r_din_valid      = '0;
        bus.r_din            = '0;
        bus.r_dout_ready     = '0;
        bus.r_force_done     = '0;
        bus.shake_din_ready  = 1'b0;
        bus.shake_dout_valid = 1'b0;
        bus.shake_dout       = '0;
    endtask

    // Owner idx ends its session; returns with the arbiter back in IDLE.
    task automatic end_session(input int idx);
        cyc();
        bus.r_force_done[idx] = 1'b1;
        bus.req[idx]          = 1'b0;
        cyc();
        bus.r_force_done = '0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        tests_run++;
        if (bus.gnt !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_gnt: got %b want 00", bus.gnt);
        end
        tests_run++;
        if ({bus.r_din_ready, bus.r_dout_valid, bus.shake_din_valid, bus.shake_dout_ready,
             bus.shake_force_done, bus.err_timeout} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outs: got %b want 00000000",
                     {bus.r_din_ready, bus.r_dout_valid, bus.shake_din_valid,
                      bus.shake_dout_ready, bus.shake_force_done, bus.err_timeout});
        end
        cyc();
        rst = 1'b0;
        $display("[TB] reset checked");
    endtask

    task automatic test_grant_order();
        bus.req = 2'b11;
        @(negedge clk);
        tests_run++;
        if (bus.gnt !== 2'b00) begin
            tests_failed++;
            $display("FAIL order_pre: got %b want 00", bus.gnt);
        end
        cyc();
        @(negedge clk);
        tests_run++;
        if (bus.gnt !== 2'b01) begin
            tests_failed++;
            $display("FAIL order_first: got %b want 01", bus.gnt);
        end
        cyc();
        bus.r_force_done = 2'b01;
        bus.req          = 2'b10;
        @(negedge clk);
        tests_run++;
        if (bus.shake_force_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL order_fd_fwd: got %b want 1", bus.shake_force_done);
        end
        cyc();
        bus.r_force_done = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus.gnt !== ((k == 3) ? 2'b10 : 2'b00)) begin
                tests_failed++;
                $display("FAIL order_turn%0d: got %b want %b", k, bus.gnt,
                         (k == 3) ? 2'b10 : 2'b00);
            end
            if (k < 3) cyc();
        end
        $display("[TB] grant order 01 then 10 checked");
        end_session(1);
    endtask

    task automatic test_stream();
        logic [DW-1:0] sent_acc, core_acc, w, exp;
        int  sent, got, k, budget;
        bit  r_hs, c_hs;
        sent_acc = '0;
        core_acc = '0;
        sent     = 0;
        got      = 0;
        budget   = 0;
        r_hs     = 1'b0;
        bus.req  = 2'b01;
        cyc();
        @(negedge clk);
        tests_run++;
        if (bus.gnt !== 2'b01) begin
            tests_failed++;
            $display("FAIL stream_gnt: got %b want 01", bus.gnt);
        end
        bus.r_din_valid[1]         = 1'b1;
        bus.r_din[2*DW-1:DW]       = 32'hDEAD_BEEF;
        while (got < 10 && budget < 300) begin
            cyc();
            budget++;
            if (r_hs) bus.r_din_valid[0] = 1'b0;
            if (!bus.r_din_valid[0] && sent < 10) begin
                w = 32'hC0DE_0000 + 32'(sent) * 32'h0001_0203;
                bus.r_din[DW-1:0]  = w;
                bus.r_din_valid[0] = 1'b1;
                exp_din_q.push_back(w);
                sent_acc = {sent_acc[30:0], sent_acc[31]} ^ w;
                sent++;
            end
            bus.shake_din_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            tests_run++;
            if ({bus.r_din_ready[1], bus.r_dout_valid[1]} !== 2'b00) begin
                tests_failed++;
                $display("FAIL stream_nonowner_in: got %b want 00",
                         {bus.r_din_ready[1], bus.r_dout_valid[1]});
            end
            r_hs = bus.r_din_valid[0] && bus.r_din_ready[0];
            c_hs = bus.shake_din_valid && bus.shake_din_ready;
            if (c_hs) begin
                tests_run++;
                exp = (exp_din_q.size() > 0) ? exp_din_q.pop_front() : 32'hxxxx_xxxx;
                if (bus.shake_din !== exp) begin
                    tests_failed++;
                    $display("FAIL stream_din%0d: got %h want %h", got, bus.shake_din, exp);
                end else begin
                    $display("[TB] din word %0d %h", got, bus.shake_din);
                end
                core_acc = {core_acc[30:0], core_acc[31]} ^ bus.shake_din;
                got++;
            end
        end
        tests_run++;
        if (got != 10) begin
            tests_failed++;
            $display("FAIL stream_din_count: got %0d want 10", got);
        end
        cyc();
        bus.r_din_valid[0]  = 1'b0;
        bus.shake_din_ready = 1'b0;
        got  = 0;
        k    = 0;
        c_hs = 1'b0;
        while (got < 16 && budget < 700) begin
            cyc();
            budget++;
            if (c_hs) bus.shake_dout_valid = 1'b0;
            if (!bus.shake_dout_valid && k < 16) begin
                bus.shake_dout       = mix(core_acc, k);
                bus.shake_dout_valid = 1'b1;
                exp_dout_q.push_back(mix(sent_acc, k));
                k++;
            end
            bus.r_dout_ready = {1'b1, 1'($urandom_range(0, 1))};
            @(negedge clk);
            tests_run++;
            if ({bus.r_din_ready[1], bus.r_dout_valid[1]} !== 2'b00) begin
                tests_failed++;
                $display("FAIL stream_nonowner_out: got %b want 00",
                         {bus.r_din_ready[1], bus.r_dout_valid[1]});
            end
            c_hs = bus.shake_dout_valid && bus.shake_dout_ready;
            if (bus.r_dout_valid[0] && bus.r_dout_ready[0]) begin
                tests_run++;
                exp = (exp_dout_q.size() > 0) ? exp_dout_q.pop_front() : 32'hxxxx_xxxx;
                if (bus.r_dout[DW-1:0] !== exp) begin
                    tests_failed++;
                    $display("FAIL stream_dout%0d: got %h want %h", got, bus.r_dout[DW-1:0], exp);
                end else begin
                    $display("[TB] dout word %0d %h", got, bus.r_dout[DW-1:0]);
                end
                got++;
            end
        end
        tests_run++;
        if (got != 16) begin
            tests_failed++;
            $display("FAIL stream_dout_count: got %0d want 16", got);
        end
        drive_idle();
        end_session(0);
    endtask

    task automatic test_nonowner_done();
        bus.req = 2'b01;
        cyc();
        cyc();
        bus.r_force_done = 2'b10;
        @(negedge clk);
        tests_run++;
        if (bus.shake_force_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL nonowner_fd: got %b want 0", bus.shake_force_done);
        end
        cyc();
        bus.r_force_done = '0;
        @(negedge clk);
        tests_run++;
        if (bus.gnt !== 2'b01) begin
            tests_failed++;
            $display("FAIL nonowner_hold: got %b want 01", bus.gnt);
        end
        $display("[TB] non-owner force_done ignored");
        end_session(0);
    endtask

    task automatic test_late_req();
        bus.req = 2'b01;
        cyc();
        cyc();
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus.gnt !== 2'b01) begin
                tests_failed++;
                $display("FAIL late_hold%0d: got %b want 01", k, bus.gnt);
            end
            cyc();
        end
        bus.r_force_done = 2'b01;
        bus.req          = 2'b10;
        cyc();
        bus.r_force_done = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus.gnt !== ((k == 3) ? 2'b10 : 2'b00)) begin
                tests_failed++;
                $display("FAIL late_turn%0d: got %b want %b", k, bus.gnt,
                         (k == 3) ? 2'b10 : 2'b00);
            end
            if (k < 3) cyc();
        end
        $display("[TB] late request waited for release");
        end_session(1);
    endtask

    task automatic test_reset_mid();
        bus.req = 2'b01;
        cyc();
        bus.r_din_valid[0]  = 1'b1;
        bus.r_din[DW-1:0]   = 32'h1234_5678;
        bus.r_dout_ready[0] = 1'b1;
        bus.shake_dout_valid = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.shake_din_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_pre: got %b want 1", bus.shake_din_valid);
        end
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.gnt, bus.r_din_ready, bus.r_dout_valid, bus.shake_din_valid,
             bus.shake_dout_ready, bus.shake_force_done, bus.err_timeout} !== 10'h000) begin
            tests_failed++;
            $display("FAIL midrst_outs: got %b want 0000000000",
                     {bus.gnt, bus.r_din_ready, bus.r_dout_valid, bus.shake_din_valid,
                      bus.shake_dout_ready, bus.shake_force_done, bus.err_timeout});
        end
        tests_run++;
        if (bus.r_dout !== '0) begin
            tests_failed++;
            $display("FAIL midrst_dout: got %h want 0", bus.r_dout);
        end
        cyc();
        cyc();
        drive_idle();
        rst     = 1'b0;
        bus.req = 2'b10;
        @(negedge clk);
        tests_run++;
        if (bus.gnt !== 2'b00) begin
            tests_failed++;
            $display("FAIL midrst_idle: got %b want 00", bus.gnt);
        end
        cyc();
        @(negedge clk);
        tests_run++;
        if (bus.gnt !== 2'b10) begin
            tests_failed++;
            $display("FAIL midrst_regrant: got %b want 10", bus.gnt);
        end
        $display("[TB] mid-session reset checked");
        end_session(1);
    endtask

`ifndef SHAKE_ARB_WATCHDOG_EN
    task automatic test_hold();
        int bad;
        bad     = 0;
        bus.req = 2'b01;
        cyc();
        cyc();
        bus.req = 2'b00;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            tests_run++;
            if (bus.gnt !== 2'b01) begin
                tests_failed++;
                $display("FAIL hold_c%0d: got %b want 01", k, bus.gnt);
                bad++;
            end
            if (bad > 3) break;
            cyc();
        end
        $display("[TB] grant held for 1000 cycles after req drop");
        end_session(0);
    endtask
`else
    task automatic test_watchdog();
        bus.req = 2'b01;
        cyc();
        bus.req = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.shake_force_done, bus.err_timeout} !== ((k == 16) ? 2'b11 : 2'b00)) begin
                tests_failed++;
                $display("FAIL wd_c%0d: got %b want %b", k,
                         {bus.shake_force_done, bus.err_timeout}, (k == 16) ? 2'b11 : 2'b00);
            end
            cyc();
        end
        bus.req = 2'b10;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.gnt, bus.err_timeout} !== ((k == 3) ? 3'b100 : 3'b000)) begin
                tests_failed++;
                $display("FAIL wd_turn%0d: got %b want %b", k, {bus.gnt, bus.err_timeout},
                         (k == 3) ? 3'b100 : 3'b000);
            end
            if (k < 3) cyc();
        end
        $display("[TB] watchdog release checked");
        end_session(1);
    endtask
`endif

    initial begin
        test_reset();
        test_grant_order();
        test_stream();
        test_nonowner_done();
        test_late_req();
        test_reset_mid();
`ifndef SHAKE_ARB_WATCHDOG_EN
        test_hold();
`else
        test_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
